ma_stage: RTL

//  Memory-access stage: consumer side of the EX/MA pipeline latch. Takes one EX/MA bundle per handshake,

---
 rtl/ma_stage_pkg.sv | 20 ++
 rtl/ma_timeout_ctr.sv | 30 +++
 rtl/ma_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ma_stage_pkg.sv
// Shared definitions for the memory-access stage: word width, bundle field widths
// and the IDLE/REQ/RESP state encoding.
package ma_stage_pkg;

  localparam int WORD    = 32;
  localparam int INSTR_W = WORD;
  localparam int PC_W    = WORD;
  localparam int DATA_W  = WORD;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_REQ  = S_REQ,
    ST_RESP = S_RESP
  } ma_state_e;

endpackage

// File: rtl/ma_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory op; expires once TIMEOUT waiting
// cycles have elapsed since the last clear.
module ma_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: accepts EX/MA bundles, runs loads/stores on the req/gnt/rvalid
// port and registers the MA/RW bundle. MA_ALIGN_CHK_EN enables misaligned-access faulting.
module ma_stage
  import ma_stage_pkg::*;
#(
  parameter int AW      = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [INSTR_W-1:0] i_in_instr,
  input  logic [PC_W-1:0]   i_in_pc,
  input  logic [DATA_W-1:0] i_in_alu_result,
  input  logic [DATA_W-1:0] i_in_op2,
  input  logic              i_in_is_ld,
  input  logic              i_in_is_st,
  input  logic              i_in_is_wb,
  input  logic              i_in_is_call,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [AW-1:0]     o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [INSTR_W-1:0] o_out_instr,
  output logic [PC_W-1:0]   o_out_pc,
  output logic [DATA_W-1:0] o_out_alu_result,
  output logic [DATA_W-1:0] o_out_ld_result,
  output logic              o_out_is_ld,
  output logic              o_out_is_wb,
  output logic              o_out_is_call,
  output logic              o_out_err
);

  ma_state_e r_state, w_state_next;
  logic w_accept, w_is_mem, w_misalign, w_issue;
  logic w_done_ok, w_done_err, w_ld_capture, w_expired;

  assign o_in_ready = (r_state == ST_IDLE) && (!o_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_is_mem   = i_in_is_ld || i_in_is_st;

`ifdef MA_ALIGN_CHK_EN
  assign w_misalign = w_is_mem && (i_in_alu_result[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = w_accept && w_is_mem && !w_misalign;

  ma_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_state_next != r_state),
    .i_en      (r_state != ST_IDLE),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // A registered read (we=0) is the load in flight; gnt wins over a same-cycle expiry.
  always_comb begin
    w_state_next = r_state;
    w_done_ok    = 1'b0;
    w_done_err   = 1'b0;
    w_ld_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (i_dmem_gnt) begin
          if (o_dmem_we || i_dmem_rvalid) begin
            w_done_ok    = 1'b1;
            w_ld_capture = !o_dmem_we;
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_RESP;
          end
        end else if (w_expired) begin
          w_done_err   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (i_dmem_rvalid) begin
          w_done_ok    = 1'b1;
          w_ld_capture = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_expired) begin
          w_done_err   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Bundle fields load at accept: the output slot is empty or draining by then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dmem_req       <= 1'b0;
      o_dmem_we        <= 1'b0;
      o_dmem_addr      <= '0;
      o_dmem_wdata     <= '0;
      o_out_valid      <= 1'b0;
      o_out_instr      <= '0;
      o_out_pc         <= '0;
      o_out_alu_result <= '0;
      o_out_ld_result  <= '0;
      o_out_is_ld      <= 1'b0;
      o_out_is_wb      <= 1'b0;
      o_out_is_call    <= 1'b0;
      o_out_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        o_out_instr      <= i_in_instr;
        o_out_pc         <= i_in_pc;
        o_out_alu_result <= i_in_alu_result;
        o_out_ld_result  <= '0;
        o_out_is_ld      <= i_in_is_ld;
        o_out_is_wb      <= i_in_is_wb && !w_misalign;
        o_out_is_call    <= i_in_is_call;
        o_out_err        <= w_misalign;
      end
      if (w_issue) begin
        o_dmem_req   <= 1'b1;
        o_dmem_we    <= i_in_is_st && !i_in_is_ld;
        o_dmem_addr  <= i_in_alu_result[AW+1:2];
        o_dmem_wdata <= i_in_op2;
      end else if (r_state == ST_REQ && (i_dmem_gnt || w_expired)) begin
        o_dmem_req <= 1'b0;
      end
      if (w_ld_capture) o_out_ld_result <= i_dmem_rdata;
      if (w_done_err) begin
        o_out_err   <= 1'b1;
        o_out_is_wb <= 1'b0;
      end
      if ((w_accept && !w_issue) || w_done_ok || w_done_err) o_out_valid <= 1'b1;
      else if (i_out_ready)                                   o_out_valid <= 1'b0;
    end
  end

endmodule
